// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: registered, multi-lane RISC-V immediate decoder.
// Each lane classifies the instruction format from its opcode. It produces
// a sign-extended immediate, a one-hot format, an illegal flag and
// pc + immediate. Results sit behind a valid/ready handshake. A main output
// register and a skid register keep one beat per cycle under back-pressure.
module imm_decode_pipe #(
  parameter int LANES = 1,
  parameter int XLEN  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [LANES-1:0]      i_lane_en,
  input  logic [32*LANES-1:0]   i_inst,
  input  logic [XLEN*LANES-1:0] i_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [LANES-1:0]      o_lane_en,
  output logic [6*LANES-1:0]    o_format,
  output logic [XLEN*LANES-1:0] o_immediate,
  output logic [XLEN*LANES-1:0] o_target,
  output logic [LANES-1:0]      o_illegal
);

  // Format one-hot bit positions
  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  typedef struct packed {
    logic [5:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            ill;
  } lane_dec_t;

  typedef struct packed {
    logic [LANES-1:0]      en;
    logic [6*LANES-1:0]    fmt;
    logic [XLEN*LANES-1:0] imm;
    logic [XLEN*LANES-1:0] tgt;
    logic [LANES-1:0]      ill;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_FULL
  } state_t;

  lane_dec_t w_dec [LANES];
  beat_t     w_beat;
  logic      w_accept;

  state_t    r_state;
  logic      r_valid;
  logic      r_ready;
  beat_t     r_main;
  beat_t     r_skid;

  // Decodes one 32-bit instruction.
  // Every recognised opcode ends in 2'b11, so compressed encodings
  // (inst[1:0] != 11) fall through to the illegal default.
  // The immediate is built at 32 bits and then sign-extended to XLEN.
  // U-type therefore extends from bit 31 on 64-bit builds.
  function automatic lane_dec_t decodeLane(input logic [31:0] inst);
    lane_dec_t   d;
    logic [31:0] imm32;
    d     = '0;
    imm32 = '0;
    case (inst[6:0])
      7'b0110011: d.fmt = FMT_R;
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        d.fmt = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        d.fmt = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        d.fmt = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        d.fmt = FMT_U;
        imm32 = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        d.fmt = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: d.ill = 1'b1;
    endcase
    d.imm = XLEN'($signed(imm32));
    return d;
  endfunction

  // Decode every lane and zero the result fields of lanes not occupied in this beat
  always_comb begin
    w_dec  = '{default: '0};
    w_beat = '0;
    w_beat.en = i_lane_en;
    for (int k = 0; k < LANES; k++) begin
      w_dec[k] = decodeLane(i_inst[32*k +: 32]);
      if (i_lane_en[k]) begin
        w_beat.fmt[6*k +: 6]       = w_dec[k].fmt;
        w_beat.imm[XLEN*k +: XLEN] = w_dec[k].imm;
        w_beat.tgt[XLEN*k +: XLEN] = i_pc[XLEN*k +: XLEN] + w_dec[k].imm;
        w_beat.ill[k]              = w_dec[k].ill;
      end
    end
  end

  assign w_accept = i_valid & r_ready;

  // Output-stage controller.
  // EMPTY holds nothing, MAIN holds one beat and FULL holds a second beat in the skid.
  // Ready and valid are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main  <= w_beat;
            r_valid <= 1'b1;
            r_state <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (w_accept && i_ready) begin
            r_main <= w_beat;
          end else if (w_accept) begin
            r_skid  <= w_beat;
            r_ready <= 1'b0;
            r_state <= ST_FULL;
          end else if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (i_ready) begin
            r_main  <= r_skid;
            r_ready <= 1'b1;
            r_state <= ST_MAIN;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_valid     = r_valid;
  assign o_ready     = r_ready;
  assign o_lane_en   = r_main.en;
  assign o_format    = r_main.fmt;
  assign o_immediate = r_main.imm;
  assign o_target    = r_main.tgt;
  assign o_illegal   = r_main.ill;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// tb_imm_decode_pipe: self-checking bench for imm_decode_pipe.
// Instance A has two 32-bit lanes and runs the handshake and stress tests.
// Instance B has one 64-bit lane and covers XLEN=64 sign extension.
module tb_imm_decode_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  logic        aValid, aOReady, aOValid, aIReady;
  logic [1:0]  aLaneEn, aOLaneEn, aIll;
  logic [63:0] aInst, aPc, aImm, aTgt;
  logic [11:0] aFormat;

  logic        bValid, bOReady, bOValid, bIReady;
  logic        bLaneEn, bOLaneEn, bIll;
  logic [31:0] bInst;
  logic [63:0] bPc, bImm, bTgt;
  logic [5:0]  bFormat;

  imm_decode_pipe #(.LANES(2), .XLEN(32)) u_dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(aValid), .o_ready(aOReady),
    .i_lane_en(aLaneEn), .i_inst(aInst), .i_pc(aPc), .o_valid(aOValid),
    .i_ready(aIReady), .o_lane_en(aOLaneEn), .o_format(aFormat),
    .o_immediate(aImm), .o_target(aTgt), .o_illegal(aIll)
  );

  imm_decode_pipe #(.LANES(1), .XLEN(64)) u_dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(bValid), .o_ready(bOReady),
    .i_lane_en(bLaneEn), .i_inst(bInst), .i_pc(bPc), .o_valid(bOValid),
    .i_ready(bIReady), .o_lane_en(bOLaneEn), .o_format(bFormat),
    .o_immediate(bImm), .o_target(bTgt), .o_illegal(bIll)
  );

  int nTests = 0;
  int nFail  = 0;
  logic afterReset = 1'b0;

  typedef struct packed {
    logic [5:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
  } laneRef_t;

  typedef struct packed {
    logic [1:0]  en;
    logic [11:0] fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [1:0]  ill;
  } beatA_t;

  beatA_t q[$];

  logic [6:0] opTable [11] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h73,
                               7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  // Reference decode: classify the opcode, then compute the immediate as a signed integer value
  function automatic laneRef_t refLane(input logic [31:0] inst, input logic [63:0] pc,
                                       input logic en, input int xlen);
    laneRef_t r;
    longint   v;
    int       fmtIdx;
    logic [63:0] mask;
    r    = '0;
    v    = 0;
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    case (inst[6:0])
      7'h33:                               fmtIdx = 0;
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73:   fmtIdx = 1;
      7'h23:                               fmtIdx = 2;
      7'h63:                               fmtIdx = 3;
      7'h37, 7'h17:                        fmtIdx = 4;
      7'h6F:                               fmtIdx = 5;
      default:                             fmtIdx = -1;
    endcase
    if (inst[1:0] != 2'b11) fmtIdx = -1;
    case (fmtIdx)
      1: begin
        v = longint'(inst[31:20]);
        if (inst[31]) v = v - 4096;
      end
      2: begin
        v = longint'({inst[31:25], inst[11:7]});
        if (inst[31]) v = v - 4096;
      end
      3: begin
        v = longint'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
        if (inst[31]) v = v - 8192;
      end
      4: begin
        v = longint'(inst[31:12]) * 4096;
        if (inst[31]) v = v - 64'h1_0000_0000;
      end
      5: begin
        v = longint'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
        if (inst[31]) v = v - (64'd1 << 21);
      end
      default: v = 0;
    endcase
    r.fmt = (fmtIdx >= 0) ? (6'b000001 << fmtIdx) : 6'b000000;
    r.ill = (fmtIdx < 0);
    r.imm = 64'(v) & mask;
    r.tgt = (pc + 64'(v)) & mask;
    if (!en) r = '0;
    return r;
  endfunction

  // Reference for one beat of the two-lane 32-bit instance
  function automatic beatA_t refBeat(input logic [1:0] en, input logic [63:0] inst,
                                     input logic [63:0] pc);
    beatA_t   b;
    laneRef_t l;
    b    = '0;
    b.en = en;
    for (int k = 0; k < 2; k++) begin
      l = refLane(inst[32*k +: 32], {32'h0, pc[32*k +: 32]}, en[k], 32);
      b.fmt[6*k +: 6]   = l.fmt;
      b.imm[32*k +: 32] = l.imm[31:0];
      b.tgt[32*k +: 32] = l.tgt[31:0];
      b.ill[k]          = l.ill;
    end
    return b;
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 8) w[6:0] = opTable[$urandom_range(0, 10)];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare instance A against the model: handshake flags follow occupancy, fields follow the queue head
  task automatic checkModel();
    checkOutput("o_valid", 64'(aOValid), 64'(q.size() > 0));
    checkOutput("o_ready", 64'(aOReady), 64'(q.size() < 2));
    if (afterReset) begin
      checkOutput("rst o_lane_en",   64'(aOLaneEn), 64'h0);
      checkOutput("rst o_format",    64'(aFormat),  64'h0);
      checkOutput("rst o_immediate", aImm,          64'h0);
      checkOutput("rst o_target",    aTgt,          64'h0);
      checkOutput("rst o_illegal",   64'(aIll),     64'h0);
    end else if (q.size() > 0) begin
      checkOutput("o_lane_en",   64'(aOLaneEn), 64'(q[0].en));
      checkOutput("o_format",    64'(aFormat),  64'(q[0].fmt));
      checkOutput("o_immediate", aImm,          q[0].imm);
      checkOutput("o_target",    aTgt,          q[0].tgt);
      checkOutput("o_illegal",   64'(aIll),     64'(q[0].ill));
    end
  endtask

  // One cycle on instance A: drive at the falling edge, advance the model, check at the next falling edge
  task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] en,
                               input logic [63:0] inst, input logic [63:0] pc,
                               input logic rdy);
    int occ;
    rstN    = !rst;
    aValid  = v;
    aLaneEn = en;
    aInst   = inst;
    aPc     = pc;
    aIReady = rdy;
    occ     = q.size();
    if (rst) begin
      q.delete();
    end else begin
      if (occ > 0 && rdy) void'(q.pop_front());
      if (v && occ < 2) q.push_back(refBeat(en, inst, pc));
    end
    @(posedge clk);
    @(negedge clk);
    afterReset = rst;
    checkModel();
  endtask

  // One beat through the 64-bit instance with the sink always ready
  task automatic bBeat(input logic [31:0] inst, input logic [63:0] pc);
    laneRef_t l;
    bValid = 1'b1;
    bInst  = inst;
    bPc    = pc;
    @(posedge clk);
    @(negedge clk);
    bValid = 1'b0;
    l = refLane(inst, pc, 1'b1, 64);
    checkOutput("B o_valid",     64'(bOValid),  64'h1);
    checkOutput("B o_lane_en",   64'(bOLaneEn), 64'h1);
    checkOutput("B o_format",    64'(bFormat),  64'(l.fmt));
    checkOutput("B o_immediate", bImm,          l.imm);
    checkOutput("B o_target",    bTgt,          l.tgt);
    checkOutput("B o_illegal",   64'(bIll),     64'(l.ill));
  endtask

  // Main sequence: reset, directed cases, back-pressure, random stress, reset while full
  initial begin
    logic [63:0] b1, b2, b3;
    rstN = 1'b0; aValid = 1'b0; aLaneEn = '0; aInst = '0; aPc = '0; aIReady = 1'b1;
    bValid = 1'b0; bLaneEn = 1'b1; bInst = '0; bPc = '0; bIReady = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);

    bBeat(32'h800002B7, 64'h0);
    checkOutput("B lui imm", bImm, 64'hFFFF_FFFF_8000_0000);
    bBeat(32'h0000007F, 64'h200);
    checkOutput("B bad ill", 64'(bIll),    64'h1);
    checkOutput("B bad fmt", 64'(bFormat), 64'h0);
    checkOutput("B bad imm", bImm,         64'h0);
    for (int i = 0; i < 20; i++) bBeat(randInst(), {$urandom, $urandom});

    applyStimulus(1'b0, 1'b1, 2'b01, {32'h0, 32'hFFF00093}, 64'h0, 1'b1);
    checkOutput("addi fmt", 64'(aFormat[5:0]), 64'h02);
    checkOutput("addi imm", 64'(aImm[31:0]),   64'hFFFF_FFFF);
    checkOutput("addi ill", 64'(aIll[0]),      64'h0);

    applyStimulus(1'b0, 1'b1, 2'b11, {32'h0080006F, 32'hFE000EE3},
                  {32'h100, 32'h100}, 1'b1);
    checkOutput("beq fmt", 64'(aFormat[5:0]),  64'h08);
    checkOutput("beq imm", 64'(aImm[31:0]),    64'hFFFF_FFFC);
    checkOutput("beq tgt", 64'(aTgt[31:0]),    64'h0000_00FC);
    checkOutput("jal fmt", 64'(aFormat[11:6]), 64'h20);
    checkOutput("jal imm", 64'(aImm[63:32]),   64'h8);
    checkOutput("jal tgt", 64'(aTgt[63:32]),   64'h108);

    applyStimulus(1'b0, 1'b1, 2'b01, {32'h800002B7, 32'hFFF00093}, 64'h0, 1'b1);
    checkOutput("off lane fmt", 64'(aFormat[11:6]), 64'h0);
    checkOutput("off lane imm", 64'(aImm[63:32]),   64'h0);
    checkOutput("off lane tgt", 64'(aTgt[63:32]),   64'h0);
    checkOutput("off lane ill", 64'(aIll[1]),       64'h0);
    checkOutput("lane_en copy", 64'(aOLaneEn),      64'h1);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);

    b1 = {randInst(), randInst()};
    b2 = {randInst(), randInst()};
    b3 = {randInst(), randInst()};
    applyStimulus(1'b0, 1'b1, 2'b11, b1, 64'h1000, 1'b0);
    checkOutput("ready after 1st", 64'(aOReady), 64'h1);
    applyStimulus(1'b0, 1'b1, 2'b11, b2, 64'h2000, 1'b0);
    checkOutput("ready after 2nd", 64'(aOReady), 64'h0);
    applyStimulus(1'b0, 1'b1, 2'b11, b3, 64'h3000, 1'b0);
    checkOutput("ready held low", 64'(aOReady), 64'h0);
    applyStimulus(1'b0, 1'b1, 2'b11, b3, 64'h3000, 1'b1);
    checkOutput("ready rises", 64'(aOReady), 64'h1);
    applyStimulus(1'b0, 1'b1, 2'b11, b3, 64'h3000, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 99) < 70), 2'($urandom),
                    {randInst(), randInst()}, {$urandom, $urandom},
                    1'($urandom_range(0, 99) < 60));
    end

    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b11, {randInst(), randInst()}, 64'h44, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, {randInst(), randInst()}, 64'h88, 1'b0);
    checkOutput("full before rst", 64'(aOReady), 64'h0);
    applyStimulus(1'b1, 1'b1, 2'b11, {randInst(), randInst()}, 64'hCC, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/imm_decode_pipe.md
Name: imm_decode_pipe

Overview:
- Registered, multi-lane successor to the combinational immediate generator.
- Each lane decodes the instruction format directly from the opcode. It produces the XLEN-wide sign-extended immediate, a one-hot format, an illegal-opcode flag and a PC-relative target.
- Sits between fetch and decode with a valid/ready handshake and an internal skid buffer, so full throughput holds under back-pressure.

Parameters:
- LANES, 1, number of instructions handled per beat (1..4).
- XLEN, 32, output datapath width (32 or 64); immediates sign-extend to XLEN.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset; one clock; synchronous, active-low.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  block can accept a beat.
- i_lane_en  input  LANES  per-lane occupancy of the beat.
- i_inst  input  32*LANES  instruction words; lane k is at [32k+31:32k].
- i_pc  input  XLEN*LANES  PC per lane.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts the output beat.
- o_lane_en  output  LANES  registered copy of i_lane_en.
- o_format  output  6*LANES  one-hot format per lane: [0]R [1]I [2]S [3]B [4]U [5]J.
- o_immediate  output  XLEN*LANES  sign-extended immediate per lane.
- o_target  output  XLEN*LANES  i_pc + immediate, modulo 2^XLEN.
- o_illegal  output  LANES  unrecognised opcode.

Behaviour:
- Opcode decode (inst[6:0]):
  - 0110011 → R.
  - 0000011, 0010011, 1100111, 0001111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Anything else → o_illegal=1, o_format=0, o_immediate=0.
- inst[1:0]!=11 counts as illegal.
- Immediates use the standard RV bit scatter.
  - I, S, B, J sign-extend from inst[31] to XLEN.
  - U = {inst[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
  - R-type immediate is 0.
- o_target is computed for every lane regardless of format; it is meaningful for B, J and AUIPC.
- Lanes with i_lane_en=0 are still decoded, but their output fields are forced to 0.
- Handshake:
  - Input accepted on i_valid & o_ready.
  - Output transferred on o_valid & i_ready.
  - Output fields stay stable while o_valid & !i_ready.
- Latency: exactly 1 cycle from acceptance to o_valid when the output stage is empty or draining.
- Storage: one main output register plus one skid register.
  - EMPTY: o_valid=0, o_ready=1. Accept → MAIN.
  - MAIN: o_valid=1, o_ready=1.
    - Accept & i_ready → MAIN with new data.
    - Accept & !i_ready → FULL (new beat goes to skid).
    - No accept & i_ready → EMPTY.
  - FULL: o_valid=1, o_ready=0. i_ready → MAIN; skid moves to main in the same cycle.
- o_ready is a registered output and has no combinational path from i_ready.
- Ordering: beats leave in acceptance order; none are dropped or duplicated.
- Reset (i_rst_n=0 at a clock edge), including mid-transfer:
  - State returns to EMPTY and all stored beats are discarded.
  - o_valid=0, o_ready=1.
  - o_lane_en, o_format, o_immediate, o_target, o_illegal are all 0.
  - Inputs are ignored during reset.
- Simultaneous accept and transfer in MAIN is a pass-through replace with no bubble; sustained throughput is 1 beat per cycle while i_ready=1.

Test Plan:
- Single lane, i_inst=0xFFF00093 (addi x1,x0,-1), i_pc=0 → next cycle o_valid=1, o_format=000010, o_immediate=0xFFFFFFFF, o_illegal=0.
- i_inst=0xFE000EE3 (beq -4), i_pc=0x100 → o_format=001000, o_immediate=0xFFFFFFFC, o_target=0x000000FC. Also i_inst=0x0080006F (jal x0,8), i_pc=0x100 → o_immediate=0x8, o_target=0x108.
- XLEN=64, i_inst=0x800002B7 (lui) → o_immediate=0xFFFFFFFF80000000. Also i_inst=0x0000007F → o_illegal=1, o_format=0, o_immediate=0.
- LANES=2, i_lane_en=01 with lane 1 holding a valid LUI → lane 1 outputs all 0. Hold i_ready=0 while streaming 3 beats:
  - o_ready drops after the 2nd accept.
  - On releasing i_ready, beats exit in order at one per cycle and o_ready rises one cycle later.
- Random valid/ready stress for 10k cycles against a reference model → no loss, no duplication, stable outputs while stalled.
- Assert i_rst_n=0 while in FULL → next cycle o_valid=0, o_ready=1, all outputs 0; the stalled beats are never emitted.
